sram_mem_controller: RTL and testbench

- Multi-cycle controller that sequences the data-memory access requested by the EX→MEM pipeline register.
- Inputs: mem_r_en, mem_w_en, alu_res (address), val_Rm (store data).
- Converts each 32-bit word access into two 16-bit accesses on an off-chip asynchronous SRAM.
- Drives freeze to stall the whole pipeline until the access completes.

---
 rtl/sram_mem_controller.sv | 199 +++++++++++++++++++
 tb/tb_sram_mem_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Data-memory controller: splits each 32-bit CPU access into two 16-bit
// asynchronous SRAM accesses and stalls the pipeline until it completes.
// Optional one-entry read cache: define SRAM_RD_CACHE_EN.
module sram_mem_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               freeze,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned WORD_W  = SRAM_AW - 1;
    localparam logic [2:0]  LAST_PH = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [2:0]          ph_r;
    logic                is_wr_r;
    logic [WORD_W-1:0]   word_r;
    logic [31:0]         wdata_r;
    logic [15:0]         lo_buf_r;
    logic [31:0]         rdata_r;
    logic                ready_r;
    logic [SRAM_AW-1:0]  addr_r;
    logic                we_n_r;
    logic                oe_n_r;
    logic                dq_oe_r;
    logic                ctrl_n_r;

    logic [WORD_W-1:0]   word_s;
    logic                last_ph_s;
    logic                we_next_s;
    logic                hit_s;
    logic [31:0]         cache_data_s;

    // Addresses below the base wrap modulo the SRAM size through the truncation.
    assign word_s    = WORD_W'((address - BASE_ADDR) >> 2);
    assign last_ph_s = (ph_r == LAST_PH);
    // Write strobe is released on the last cycle of each half so data is held past we_n rising.
    assign we_next_s = ~(is_wr_r & ((ph_r + 3'd1) != LAST_PH));

`ifdef SRAM_RD_CACHE_EN
    logic                c_valid_r;
    logic [WORD_W-1:0]   c_tag_r;
    logic [31:0]         c_data_r;
    logic                fin_s;

    assign hit_s        = c_valid_r & (c_tag_r == word_s);
    assign cache_data_s = c_data_r;
    assign fin_s        = (state_r == S_HIGH) & last_ph_s;

    // One-entry read cache: filled by read misses, kept coherent with writes to its tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_valid_r <= 1'b0;
            c_tag_r   <= '0;
            c_data_r  <= 32'h0000_0000;
        end else if (fin_s && !is_wr_r) begin
            c_valid_r <= 1'b1;
            c_tag_r   <= word_r;
            c_data_r  <= {sram_dq, lo_buf_r};
        end else if (fin_s && c_valid_r && (c_tag_r == word_r)) begin
            c_data_r  <= wdata_r;
        end else begin
            c_data_r  <= c_data_r;
        end
    end
`else
    assign hit_s        = 1'b0;
    assign cache_data_s = 32'h0000_0000;
`endif

    // Access sequencer: IDLE -> LOW -> HIGH -> DONE with registered SRAM controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            ph_r     <= 3'd0;
            is_wr_r  <= 1'b0;
            word_r   <= '0;
            wdata_r  <= 32'h0000_0000;
            lo_buf_r <= 16'h0000;
            rdata_r  <= 32'h0000_0000;
            ready_r  <= 1'b0;
            addr_r   <= '0;
            we_n_r   <= 1'b1;
            oe_n_r   <= 1'b1;
            dq_oe_r  <= 1'b0;
            ctrl_n_r <= 1'b1;
        end else begin
            ctrl_n_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    ready_r <= 1'b0;
                    ph_r    <= 3'd0;
                    if (mem_w_en) begin
                        state_r <= S_LOW;
                        is_wr_r <= 1'b1;
                        word_r  <= word_s;
                        wdata_r <= wdata;
                        addr_r  <= {word_s, 1'b0};
                        we_n_r  <= 1'b0;
                        oe_n_r  <= 1'b1;
                        dq_oe_r <= 1'b1;
                    end else if (mem_r_en && hit_s) begin
                        state_r <= S_DONE;
                        is_wr_r <= 1'b0;
                        word_r  <= word_s;
                        ready_r <= 1'b1;
                        rdata_r <= cache_data_s;
                    end else if (mem_r_en) begin
                        state_r <= S_LOW;
                        is_wr_r <= 1'b0;
                        word_r  <= word_s;
                        addr_r  <= {word_s, 1'b0};
                        we_n_r  <= 1'b1;
                        oe_n_r  <= 1'b0;
                        dq_oe_r <= 1'b0;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOW: begin
                    if (last_ph_s) begin
                        state_r  <= S_HIGH;
                        ph_r     <= 3'd0;
                        addr_r   <= {word_r, 1'b1};
                        lo_buf_r <= sram_dq;
                        we_n_r   <= ~is_wr_r;
                    end else begin
                        ph_r     <= ph_r + 3'd1;
                        we_n_r   <= we_next_s;
                    end
                end
                S_HIGH: begin
                    if (last_ph_s) begin
                        state_r <= S_DONE;
                        ph_r    <= 3'd0;
                        ready_r <= 1'b1;
                        we_n_r  <= 1'b1;
                        oe_n_r  <= 1'b1;
                        dq_oe_r <= 1'b0;
                        if (!is_wr_r) begin
                            rdata_r <= {sram_dq, lo_buf_r};
                        end else begin
                            rdata_r <= rdata_r;
                        end
                    end else begin
                        ph_r    <= ph_r + 3'd1;
                        we_n_r  <= we_next_s;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b0;
                    we_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    dq_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign sram_dq   = dq_oe_r ? ((state_r == S_HIGH) ? wdata_r[31:16] : wdata_r[15:0]) : 16'hzzzz;
    assign sram_addr = addr_r;
    assign sram_we_n = we_n_r;
    assign sram_oe_n = oe_n_r;
    assign sram_ce_n = ctrl_n_r;
    assign sram_ub_n = ctrl_n_r;
    assign sram_lb_n = ctrl_n_r;
    assign rdata     = rdata_r;
    assign ready     = ready_r;
    assign freeze    = (mem_r_en | mem_w_en) & ~ready_r;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: vector table, hand-written
// corner sequences and randomized traffic against a word-level memory model.
module tb_sram_mem_controller;

    localparam int W      = 1;
    localparam int FULL   = 2 * (W + 1) + 1;
    localparam int WE_EXP = (W == 0) ? 2 : 2 * W;
    localparam int OE_EXP = 2 * W + 2;
`ifdef SRAM_RD_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, wdata, rdata;
    logic        ready, freeze;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    // second instance with WAIT_CYCLES=0 for the short-latency check
    logic        r0;
    logic [31:0] a0, rd0;
    logic        rdy0, frz0, we0, oe0, ce0, ub0, lb0;
    wire  [15:0] dq0;
    logic [17:0] sa0;

    sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
        .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0), .SRAM_AW(18)) dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r0), .mem_w_en(1'b0),
        .address(a0), .wdata(32'h0000_0000), .rdata(rd0), .ready(rdy0), .freeze(frz0),
        .sram_dq(dq0), .sram_addr(sa0), .sram_we_n(we0), .sram_oe_n(oe0),
        .sram_ce_n(ce0), .sram_ub_n(ub0), .sram_lb_n(lb0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models
    logic [15:0] mem [0:262143];
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq;
    end
    assign dq0 = !oe0 ? ((sa0 == 18'd3) ? 16'hABCD : ((sa0 == 18'd2) ? 16'h1234 : 16'h0000)) : 16'hzzzz;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model (word granularity) ----------------
    logic [31:0] ref_w [logic [16:0]];
    bit          c_valid = 1'b0;
    logic [16:0] c_tag = 17'd0;
    logic [31:0] last_rdata = 32'h0;

    function automatic logic [15:0] pat(input logic [17:0] i);
        return i[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return off[18:2];
    endfunction

    function automatic logic [31:0] ref_read(input logic [16:0] w);
        if (ref_w.exists(w)) return ref_w[w];
        return {pat({w, 1'b1}), pat({w, 1'b0})};
    endfunction

    // ---------------- access driver ----------------
    int          we_cnt, oe_cnt, freeze_bad, last_lat;
    logic [17:0] cap_addr [0:15];
    logic [15:0] cap_dq   [0:15];

    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input int exp_lat, output int lat);
        mem_w_en = wr; mem_r_en = rd; address = addr; wdata = data;
        lat = -1; we_cnt = 0; oe_cnt = 0; freeze_bad = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                if (we_cnt < 16) begin
                    cap_addr[we_cnt] = sram_addr;
                    cap_dq[we_cnt]   = sram_dq;
                end
                we_cnt++;
            end
            if (!sram_oe_n) oe_cnt++;
            if (freeze !== (c < exp_lat)) freeze_bad++;
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_w_en = 1'b0; mem_r_en = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
        int el, ewe, eoe, lat;
        bit hit;
        logic [16:0] w;
        w = word_of(addr);
        if (wr) begin
            ref_w[w] = data; el = FULL; ewe = WE_EXP; eoe = 0;
        end else begin
            hit = CACHE_ON && c_valid && (c_tag == w);
            last_rdata = ref_read(w);
            el = hit ? 1 : FULL; eoe = hit ? 0 : OE_EXP; ewe = 0;
            if (!hit) begin
                c_valid = 1'b1; c_tag = w;
            end
        end
        run_access(wr, rd, addr, data, el, lat);
        last_lat = lat;
        chk("latency", lat, el);
        chk("rdata", rdata, last_rdata);
        chk("we_cycles", we_cnt, ewe);
        chk("oe_cycles", oe_cnt, eoe);
        chk("freeze", freeze_bad, 0);
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt [11];

    initial begin
        int lat0;
        rst = 1'b0; mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'd1028; wdata = 32'h0;
        r0 = 1'b0; a0 = 32'd0;
        for (int i = 0; i < 262144; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
        mem[2] <= 16'h1234;
        mem[3] <= 16'hABCD;
        ref_w[17'd1] = 32'hABCD1234;

        vt[0]  = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 32'hABCD1234};
        vt[1]  = '{1'b0, 1'b1, 32'd1028,   32'h0,        32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b0, 32'd2048,   32'h00000000, 32'hDEADBEEF};
        vt[3]  = '{1'b0, 1'b1, 32'd2048,   32'h0,        32'h00000000};
        vt[4]  = '{1'b0, 1'b1, 32'd1064,   32'h0,        32'h5A4F5A4E};
        vt[5]  = '{1'b1, 1'b1, 32'd1024,   32'h13572468, 32'h5A4F5A4E};
        vt[6]  = '{1'b0, 1'b1, 32'd1024,   32'h0,        32'h13572468};
        vt[7]  = '{1'b1, 1'b0, 32'd1020,   32'hA5A5C3C3, 32'h13572468};
        vt[8]  = '{1'b0, 1'b1, 32'd1020,   32'h0,        32'hA5A5C3C3};
        vt[9]  = '{1'b0, 1'b1, 32'd525312, 32'h0,        32'h13572468};
        vt[10] = '{1'b0, 1'b1, 32'd1031,   32'h0,        32'hDEADBEEF};

        // reset held with a pending load
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 1'b0);
        chk("rst_freeze", freeze, 1'b1);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_addr", sram_addr, 18'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dq_released", dut.dq_oe_r, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        txn(1'b0, 1'b1, 32'd1028, 32'h0);
        chk("load_after_rst", rdata, 32'hABCD1234);
        chk("ctrl_tied_low", {sram_ce_n, sram_ub_n, sram_lb_n}, 3'b000);

        // zero-wait instance: ready at cycle 3
        r0 = 1'b1; a0 = 32'd1028; lat0 = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rdy0) begin
                lat0 = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("w0_latency", lat0, 3);
        chk("w0_rdata", rd0, 32'hABCD1234);
        chk("w0_no_write", we0, 1'b1);
        chk("w0_ctrl", {ce0, ub0, lb0}, 3'b000);
        @(posedge clk); #1;
        r0 = 1'b0;
        @(negedge clk);
        chk("w0_idle_freeze", frz0, 1'b0);
        @(posedge clk); #1;

        // vector table, issued back-to-back
        for (int i = 0; i < 11; i++) begin
            txn(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data);
            chk("tbl_rdata", rdata, vt[i].exp_rdata);
            if (vt[i].wr) begin
                chk("tbl_lo_addr", cap_addr[0], {word_of(vt[i].addr), 1'b0});
                chk("tbl_lo_dq", cap_dq[0], vt[i].data[15:0]);
                chk("tbl_hi_addr", cap_addr[WE_EXP / 2], {word_of(vt[i].addr), 1'b1});
                chk("tbl_hi_dq", cap_dq[WE_EXP / 2], vt[i].data[31:16]);
            end
        end

        // reset during the high half of a store: high halfword must stay unwritten
        mem_w_en = 1'b1; address = 32'd1032; wdata = 32'hCAFEF00D;
        repeat (W + 2) @(posedge clk);
        #2;
        rst = 1'b0;
        mem_w_en = 1'b0;
        #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_oe_n", sram_oe_n, 1'b1);
        chk("abort_ready", ready, 1'b0);
        chk("abort_addr", sram_addr, 18'd0);
        chk("abort_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        chk("abort_lo_written", mem[4], 16'hF00D);
        chk("abort_hi_untouched", mem[5], 16'h5A5F);
        rst = 1'b1;
        ref_w[17'd2] = 32'h5A5FF00D; last_rdata = 32'h0; c_valid = 1'b0;
        txn(1'b0, 1'b1, 32'd1032, 32'h0);
        chk("abort_readback", rdata, 32'h5A5FF00D);

`ifdef SRAM_RD_CACHE_EN
        txn(1'b0, 1'b1, 32'd1028, 32'h0);
        txn(1'b0, 1'b1, 32'd1028, 32'h0);
        chk("cache_hit_lat", last_lat, 1);
        chk("cache_hit_oe", oe_cnt, 0);
        txn(1'b1, 1'b0, 32'd1028, 32'h0);
        txn(1'b0, 1'b1, 32'd1028, 32'h0);
        chk("cache_upd_lat", last_lat, 1);
        chk("cache_upd_data", rdata, 32'h00000000);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            int op;
            logic [31:0] ra;
            op = $urandom_range(0, 9);
            ra = 32'd1024 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            if (op < 4)      txn(1'b1, 1'b0, ra, $urandom);
            else if (op < 9) txn(1'b0, 1'b1, ra, 32'h0);
            else             txn(1'b1, 1'b1, ra, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("idle_freeze", freeze, 1'b0);
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
